sobel_window_ctrl: RTL and testbench



---
 rtl/sobel_pkg.sv | 19 +
 rtl/sobel_window_ctrl_if.sv | 24 ++
 rtl/sobel_pixel_coord.sv | 70 +++++++
 rtl/sobel_window_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sobel_window_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel front end.
//   - sobel_state_e : window controller sequencing states
//   - default image geometry and the line-FIFO depth that must match IMG_WIDTH
package sobel_pkg;

  localparam int unsigned ImgWidthDefault  = 256;
  localparam int unsigned ImgHeightDefault = 256;

  // Each line FIFO delays by exactly one image line.
  localparam int unsigned LineFifoDepth = ImgWidthDefault;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StStream,
    StDone
  } sobel_state_e;

endpackage

// File: rtl/sobel_window_ctrl_if.sv
// Pixel-stream handshake between the upstream source and the window controller.
//   PixValid   : upstream has a pixel
//   PixReady   : controller can accept a pixel
//   LineEnable : shift enable for both line FIFOs and the 3x3 window registers
// Modports: master = upstream/pixel path side, slave = controller.
interface sobel_window_ctrl_if;

  logic PixValid;
  logic PixReady;
  logic LineEnable;

  modport master (
    output PixValid,
    input  PixReady,
    input  LineEnable
  );

  modport slave (
    input  PixValid,
    output PixReady,
    output LineEnable
  );

endinterface

// File: rtl/sobel_pixel_coord.sv
// Raster row/column tracker for the Sobel window controller.
// Ports:
//   clk_i        : clock
//   rst_i        : synchronous active-high reset (clears to 0,0)
//   clr_i        : clear to 0,0 at frame start
//   adv_i        : advance one pixel (an accepted pixel)
//   row_o/col_o  : position of the next pixel to be accepted
//   last_col_o   : current column is the last of the line
//   last_pixel_o : current position is the last pixel of the frame
//   interior_o   : row >= 2 and col >= 2, i.e. a full 3x3 neighbourhood exists
module sobel_pixel_coord #(
  parameter int unsigned Width  = 256,
  parameter int unsigned Height = 256,
  parameter int unsigned ColW   = 8,
  parameter int unsigned RowW   = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clr_i,
  input  logic            adv_i,
  output logic [RowW-1:0] row_o,
  output logic [ColW-1:0] col_o,
  output logic            last_col_o,
  output logic            last_pixel_o,
  output logic            interior_o
);

  localparam logic [ColW-1:0] LastCol = ColW'(Width - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(Height - 1);

  logic [RowW-1:0] row_q, row_d;
  logic [ColW-1:0] col_q, col_d;

  assign last_col_o   = (col_q == LastCol);
  assign last_pixel_o = last_col_o && (row_q == LastRow);
  assign interior_o   = (row_q >= RowW'(2)) && (col_q >= ColW'(2));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (adv_i) begin
      if (last_col_o) begin
        col_d = '0;
        // Row never wraps inside a frame; it parks on the last line.
        if (row_q != LastRow) begin
          row_d = row_q + RowW'(1);
        end
      end else begin
        col_d = col_q + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o = row_q;
  assign col_o = col_q;

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sequencer for the Sobel front end: accepts a raster pixel stream, drives the
// shared shift enable of the two cascaded line FIFOs and window registers, and
// flags each cycle on which the window holds a full interior 3x3 neighbourhood.
// Ports:
//   CLK, Reset  : clock, synchronous active-high reset
//   Start       : frame start request, honoured only while idle
//   pix         : pixel handshake (PixValid in; PixReady, LineEnable out)
//   WinValid    : window registers hold an interior neighbourhood
//   WinRow/Col  : centre of that neighbourhood
//   Busy        : frame in progress (including the done cycle)
//   FrameDone   : one-cycle pulse after the last pixel is accepted
//   StallCount  : cycles with no upstream pixel while streaming
// Build option: define SOBEL_STALL_CNT_EN to implement StallCount; otherwise
// the port is tied to zero.
module sobel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = ImgWidthDefault,
  parameter int unsigned IMG_HEIGHT = ImgHeightDefault,
  parameter int unsigned COL_W      = 8,
  parameter int unsigned ROW_W      = 8
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Start,
  sobel_window_ctrl_if.slave  pix,
  output logic                WinValid,
  output logic [ROW_W-1:0]    WinRow,
  output logic [COL_W-1:0]    WinCol,
  output logic                Busy,
  output logic                FrameDone,
  output logic [15:0]         StallCount
);

  sobel_state_e state_q, state_d;

  logic             streaming;
  logic             accept;
  logic             coord_clr;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic             last_col;
  logic             last_pixel;
  logic             interior;
  logic             frame_end;

  logic             win_valid_q, win_valid_d;
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic [COL_W-1:0] win_col_q, win_col_d;

  assign streaming      = (state_q == StFill) || (state_q == StStream);
  assign pix.PixReady   = streaming;
  assign accept         = pix.PixValid && streaming;
  // FIFOs and window registers shift only on accepted pixels.
  assign pix.LineEnable = accept;
  assign Busy           = (state_q != StIdle);
  assign FrameDone      = (state_q == StDone);
  assign frame_end      = accept && last_col && last_pixel;

  sobel_pixel_coord #(
    .Width  (IMG_WIDTH),
    .Height (IMG_HEIGHT),
    .ColW   (COL_W),
    .RowW   (ROW_W)
  ) u_coord (
    .clk_i        (CLK),
    .rst_i        (Reset),
    .clr_i        (coord_clr),
    .adv_i        (accept),
    .row_o        (row),
    .col_o        (col),
    .last_col_o   (last_col),
    .last_pixel_o (last_pixel),
    .interior_o   (interior)
  );

  always_comb begin
    state_d   = state_q;
    coord_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          state_d   = StFill;
          coord_clr = 1'b1;
        end
      end
      StFill: begin
        // A frame too small to reach streaming ends straight from fill.
        if (frame_end) begin
          state_d = StDone;
        end else if (accept && interior) begin
          state_d = StStream;
        end
      end
      StStream: begin
        if (frame_end) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // The window registers load on the accepting edge, so the centre of the
  // neighbourhood is one row up and one column left of the accepted pixel.
  always_comb begin
    win_valid_d = accept && interior;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (win_valid_d) begin
      win_row_d = row - ROW_W'(1);
      win_col_d = col - COL_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else begin
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
    end
  end

  assign WinValid = win_valid_q;
  assign WinRow   = win_row_q;
  assign WinCol   = win_col_q;

`ifdef SOBEL_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if ((state_q == StIdle) && Start) begin
      stall_d = '0;
    end else if (streaming && !pix.PixValid && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign StallCount = stall_q;
`else
  assign StallCount = '0;
`endif

endmodule

// File: tb/tb_sobel_window_ctrl.sv
module tb_sobel_window_ctrl;

  localparam int W = 8;
  localparam int H = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic        WinValid;
  logic [1:0]  WinRow;
  logic [2:0]  WinCol;
  logic        Busy;
  logic        FrameDone;
  logic [15:0] StallCount;

  sobel_window_ctrl_if bus ();

  always #5 CLK = ~CLK;

  sobel_window_ctrl #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .COL_W      (3),
    .ROW_W      (2)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Start      (Start),
    .pix        (bus),
    .WinValid   (WinValid),
    .WinRow     (WinRow),
    .WinCol     (WinCol),
    .Busy       (Busy),
    .FrameDone  (FrameDone),
    .StallCount (StallCount)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is "pixels accepted so far" out of W*H; the
  // window centre follows from the pixel index by plain division.
  bit m_active = 0;
  bit m_done   = 0;
  bit m_wv     = 0;
  bit armed    = 0;
  int m_n      = 0;
  int m_wr     = 0;
  int m_wc     = 0;
  int m_stall  = 0;

  int wq_r[$];
  int wq_c[$];
  int edge_hits = 0;
  int fd_count  = 0;

  initial begin
    forever begin
      @(posedge CLK);
      if (Reset === 1'b1) begin
        m_active = 0;
        m_done   = 0;
        m_wv     = 0;
        m_n      = 0;
        m_stall  = 0;
        armed    = 1;
      end else if (armed) begin
        bit acc;
        int r;
        int c;
        acc  = m_active && (bus.PixValid === 1'b1);
        m_wv = 0;
        if (acc) begin
          r = m_n / W;
          c = m_n % W;
          if (r >= 2 && c >= 2) begin
            m_wv = 1;
            m_wr = r - 1;
            m_wc = c - 1;
          end
          m_n++;
        end
        if (m_active && bus.PixValid !== 1'b1 && m_stall < 65535) m_stall++;
        if (m_done) begin
          m_done = 0;
        end else if (!m_active && Start === 1'b1) begin
          m_active = 1;
          m_n      = 0;
          m_stall  = 0;
        end
        if (acc && m_n == W * H) begin
          m_active = 0;
          m_done   = 1;
        end
      end
      @(negedge CLK);
      if (armed) begin
        check("pix_ready", bus.PixReady, m_active);
        check("line_enable", bus.LineEnable, (bus.PixValid === 1'b1) && m_active);
        check("busy", Busy, m_active || m_done);
        check("frame_done", FrameDone, m_done);
        check("win_valid", WinValid, m_wv);
        if (m_wv) begin
          check("win_row", WinRow, m_wr);
          check("win_col", WinCol, m_wc);
        end
`ifdef SOBEL_STALL_CNT_EN
        check("stall_count", StallCount, m_stall);
`else
        check("stall_count", StallCount, 0);
`endif
        if (WinValid === 1'b1) begin
          wq_r.push_back(int'(WinRow));
          wq_c.push_back(int'(WinCol));
          // Edge columns c=0/c=1 would show up as centre column 7 or 0.
          if (WinCol == 3'd0 || WinCol == 3'd7) edge_hits++;
        end
        if (FrameDone === 1'b1) fd_count++;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic run_frame(input bit toggle, input int start_at, input int abort_at);
    int acc = 0;
    int cyc = 0;
    int w0;
    int e0;
    int f0;
    bit pv = 1;
    w0 = wq_r.size();
    e0 = edge_hits;
    f0 = fd_count;
    bus.PixValid = 1'b0;
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("fill_ready", bus.PixReady, 1);
    while (acc < W * H && acc != abort_at && cyc < 400) begin
      bus.PixValid = pv;
      Start = (start_at >= 0) && (acc == start_at);
      step();
      cyc++;
      if (pv) acc++;
      if (toggle) pv = !pv;
    end
    bus.PixValid = 1'b0;
    Start = 1'b0;
    if (cyc >= 400) check("frame_timeout", cyc, 0);
    if (abort_at >= 0) begin
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      check("abort_ready", bus.PixReady, 0);
      check("abort_busy", Busy, 0);
      check("abort_win_valid", WinValid, 0);
      check("abort_windows", wq_r.size() - w0, 2);
      check("abort_no_done", fd_count - f0, 0);
    end else begin
      check("done_pulse", FrameDone, 1);
      check("done_ready", bus.PixReady, 0);
`ifdef SOBEL_STALL_CNT_EN
      if (toggle) check("stall_at_done", StallCount, 31);
`endif
      step();
      check("done_single", FrameDone, 0);
      check("idle_ready", bus.PixReady, 0);
      check("idle_busy", Busy, 0);
      check("win_count", wq_r.size() - w0, 12);
      if (wq_r.size() >= w0 + 12) begin
        check("first_row", wq_r[w0], 1);
        check("first_col", wq_c[w0], 1);
        check("last_row", wq_r[w0 + 11], 2);
        check("last_col", wq_c[w0 + 11], 6);
      end
      check("edge_cols", edge_hits - e0, 0);
      check("fd_count", fd_count - f0, 1);
    end
  endtask

  initial begin
    int w_idle;
    Reset = 1'b1;
    Start = 1'b0;
    bus.PixValid = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    Reset = 1'b0;
    check("rst_ready", bus.PixReady, 0);
    check("rst_win_valid", WinValid, 0);
    check("rst_win_row", WinRow, 0);
    check("rst_win_col", WinCol, 0);
    check("rst_busy", Busy, 0);
    check("rst_frame_done", FrameDone, 0);
    check("rst_stall", StallCount, 0);
    step();

    run_frame(1'b0, -1, -1);   // continuous stream
    run_frame(1'b1, -1, -1);   // valid toggling 1,0,1,0
    run_frame(1'b0, 25, -1);   // Start pulsed mid-stream
    run_frame(1'b0, -1, 20);   // reset after 20 pixels
    step();
    run_frame(1'b0, -1, -1);   // fresh frame after reset

    // Valid held while idle without Start must not move anything.
    w_idle = wq_r.size();
    bus.PixValid = 1'b1;
    repeat (5) begin
      step();
      check("idle_hold_ready", bus.PixReady, 0);
      check("idle_hold_le", bus.LineEnable, 0);
    end
    bus.PixValid = 1'b0;
    check("idle_hold_windows", wq_r.size() - w_idle, 0);
    run_frame(1'b0, -1, -1);

    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
